// File: rtl/fp_normalize_round_stage_pkg.sv
// Shared definitions for the FP normalise/round/pack stage.
// Holds the default lane count, FP32 field widths, the GRS width and the canonical NaN.
package fp_normalize_round_stage_pkg;

  localparam int LANES_DEFAULT          = 16;
  localparam int SIDEBAND_WIDTH_DEFAULT = 64;

  // IEEE single-precision field widths.
  localparam int FP32_EXP_WIDTH  = 8;
  localparam int FP32_FRAC_WIDTH = 23;

  // Guard, round and sticky bits trail the fraction in the incoming significand.
  localparam int GRS_WIDTH = 3;

  typedef struct packed {
    logic                       sign;
    logic [FP32_EXP_WIDTH-1:0]  exp;
    logic [FP32_FRAC_WIDTH-1:0] frac;
  } fp32_t;

  // Quiet NaN with positive sign and only the fraction MSB set.
  localparam fp32_t FP32_CANONICAL_NAN = fp32_t'(32'h7FC0_0000);

  // Width of a normalisation shift count for a significand of {hidden, frac, G, R, S}.
  function automatic int norm_shift_width(input int frac_width);
    return $clog2(frac_width + 1 + GRS_WIDTH);
  endfunction

endpackage

// File: rtl/fp_normalize_round_stage_if.sv
// Handshake and datapath bundle between the align/add stage, this stage and writeback.
// master drives the op in and accepts the result; slave is the normalise/round stage.
interface fp_normalize_round_stage_if
  import fp_normalize_round_stage_pkg::*;
#(
  parameter int LANES          = LANES_DEFAULT,
  parameter int EXP_WIDTH      = FP32_EXP_WIDTH,
  parameter int FRAC_WIDTH     = FP32_FRAC_WIDTH,
  parameter int SIDEBAND_WIDTH = SIDEBAND_WIDTH_DEFAULT
) ();

  localparam int SIG_WIDTH    = FRAC_WIDTH + 1 + GRS_WIDTH;
  localparam int SHIFT_WIDTH  = norm_shift_width(FRAC_WIDTH);
  localparam int RESULT_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;

  logic                            in_valid;
  logic                            in_ready;
  logic [SIDEBAND_WIDTH-1:0]       in_sideband;
  logic [LANES*SIG_WIDTH-1:0]      in_significand;
  logic [LANES*EXP_WIDTH-1:0]      in_exponent;
  logic [LANES*SHIFT_WIDTH-1:0]    in_norm_shift;
  logic [LANES-1:0]                in_sign;
  logic [LANES-1:0]                in_logical_subtract;
  logic [LANES-1:0]                in_is_nan;
  logic [LANES-1:0]                in_is_inf;

  logic                            out_valid;
  logic                            out_ready;
  logic [SIDEBAND_WIDTH-1:0]       out_sideband;
  logic [LANES*RESULT_WIDTH-1:0]   out_result;

  modport master (
    output in_valid, in_sideband, in_significand, in_exponent, in_norm_shift,
           in_sign, in_logical_subtract, in_is_nan, in_is_inf, out_ready,
    input  in_ready, out_valid, out_sideband, out_result
  );

  modport slave (
    input  in_valid, in_sideband, in_significand, in_exponent, in_norm_shift,
           in_sign, in_logical_subtract, in_is_nan, in_is_inf, out_ready,
    output in_ready, out_valid, out_sideband, out_result
  );

endinterface

// File: rtl/fp_round_pack_lane.sv
// Combinational per-lane round-to-nearest-even, special-case selection and packing.
// Takes a normalised significand {hidden, frac, G, R, S} and a signed exponent.
module fp_round_pack_lane
  import fp_normalize_round_stage_pkg::*;
#(
  parameter int EXP_WIDTH  = FP32_EXP_WIDTH,
  parameter int FRAC_WIDTH = FP32_FRAC_WIDTH
) (
  input  logic [FRAC_WIDTH+GRS_WIDTH:0]      sig,
  input  logic signed [EXP_WIDTH+1:0]        exp,
  input  logic                               sign,
  input  logic                               is_nan,
  input  logic                               is_inf,
  output logic [EXP_WIDTH+FRAC_WIDTH:0]      result
);

  localparam int SIG_WIDTH    = FRAC_WIDTH + 1 + GRS_WIDTH;
  localparam int MANT_WIDTH   = FRAC_WIDTH + 1;
  localparam int EXPI_WIDTH   = EXP_WIDTH + 2;
  localparam int RESULT_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;

  localparam logic signed [EXPI_WIDTH-1:0] EXP_ZERO     = '0;
  localparam logic signed [EXPI_WIDTH-1:0] EXP_ALL_ONES = {2'b00, {EXP_WIDTH{1'b1}}};

  // FP32 lanes reuse the shared constant so every block agrees on one NaN encoding.
  localparam logic [RESULT_WIDTH-1:0] NAN_PATTERN =
    (EXP_WIDTH == FP32_EXP_WIDTH && FRAC_WIDTH == FP32_FRAC_WIDTH)
      ? RESULT_WIDTH'(FP32_CANONICAL_NAN)
      : {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};

  logic [MANT_WIDTH-1:0]          mant;
  logic                           guard_bit;
  logic                           round_bit;
  logic                           sticky_bit;
  logic                           round_up;
  logic [MANT_WIDTH:0]            mant_sum;
  logic                           carry;
  logic [FRAC_WIDTH-1:0]          frac_rounded;
  logic signed [EXPI_WIDTH-1:0]   exp_rounded;

  assign mant       = sig[SIG_WIDTH-1:GRS_WIDTH];
  assign guard_bit  = sig[GRS_WIDTH-1];
  assign round_bit  = sig[GRS_WIDTH-2];
  assign sticky_bit = sig[GRS_WIDTH-3];

  // Nearest-even: round up above the halfway point, or at the tie when the LSB is odd.
  assign round_up = guard_bit & (round_bit | sticky_bit | mant[0]);
  assign mant_sum = {1'b0, mant} + {{MANT_WIDTH{1'b0}}, round_up};

  // A carry out of the hidden bit means the mantissa wrapped to 10.000...; renormalise by one.
  assign carry        = mant_sum[MANT_WIDTH];
  assign frac_rounded = carry ? mant_sum[MANT_WIDTH-1:1] : mant_sum[FRAC_WIDTH-1:0];
  assign exp_rounded  = exp + $signed({{(EXPI_WIDTH-1){1'b0}}, carry});

  // Priority select of the packed result: NaN, infinity, exact zero, underflow, overflow, normal.
  always_comb begin
    result = {sign, exp_rounded[EXP_WIDTH-1:0], frac_rounded};
    if (is_nan) begin
      result = NAN_PATTERN;
    end else if (is_inf) begin
      result = {sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
    end else if (!sig[SIG_WIDTH-1]) begin
      result = {sign, {(EXP_WIDTH+FRAC_WIDTH){1'b0}}};
    end else if (exp_rounded <= EXP_ZERO) begin
      // No denormal support: anything at or below the minimum exponent flushes to zero.
      result = {sign, {(EXP_WIDTH+FRAC_WIDTH){1'b0}}};
    end else if (exp_rounded >= EXP_ALL_ONES) begin
      result = {sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
    end
  end

endmodule

// File: rtl/fp_normalize_round_stage.sv
// Final FP add/mul stage for LANES parallel lanes: normalise (stage A), then round,
// handle specials and pack (stage B). Each stage is a register with valid/ready
// flow control; the sideband travels alongside its op through both stages.
module fp_normalize_round_stage
  import fp_normalize_round_stage_pkg::*;
#(
  parameter int LANES          = LANES_DEFAULT,
  parameter int EXP_WIDTH      = FP32_EXP_WIDTH,
  parameter int FRAC_WIDTH     = FP32_FRAC_WIDTH,
  parameter int SIDEBAND_WIDTH = SIDEBAND_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  fp_normalize_round_stage_if.slave bus
);

  localparam int SIG_WIDTH    = FRAC_WIDTH + 1 + GRS_WIDTH;
  localparam int SHIFT_WIDTH  = norm_shift_width(FRAC_WIDTH);
  localparam int EXPI_WIDTH   = EXP_WIDTH + 2;
  localparam int RESULT_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;

  // Flow control
  logic a_valid_reg;
  logic b_valid_reg;
  logic a_advance;
  logic b_advance;

  // Stage A state: normalised significand and signed exponent per lane
  logic [LANES-1:0][SIG_WIDTH-1:0]   a_sig_next;
  logic [LANES-1:0][EXPI_WIDTH-1:0]  a_exp_next;
  logic [LANES-1:0][SIG_WIDTH-1:0]   a_sig_reg;
  logic [LANES-1:0][EXPI_WIDTH-1:0]  a_exp_reg;
  logic [LANES-1:0]                  a_sign_reg;
  logic [LANES-1:0]                  a_nan_reg;
  logic [LANES-1:0]                  a_inf_reg;
  logic [SIDEBAND_WIDTH-1:0]         a_sideband_reg;

  // Stage B state: packed results, driven straight to the output
  logic [LANES*RESULT_WIDTH-1:0]     b_result_next;
  logic [LANES*RESULT_WIDTH-1:0]     out_result_reg;
  logic [SIDEBAND_WIDTH-1:0]         out_sideband_reg;

  // B drains when empty or when downstream accepts; A drains when empty or B drains.
  assign b_advance = !b_valid_reg || bus.out_ready;
  assign a_advance = !a_valid_reg || b_advance;

  assign bus.in_ready     = a_advance;
  assign bus.out_valid    = b_valid_reg;
  assign bus.out_result   = out_result_reg;
  assign bus.out_sideband = out_sideband_reg;

  genvar gi;

  // Normalisation shift per lane; only effective subtractions can produce leading zeros.
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_norm
      logic [SIG_WIDTH-1:0]   sig_in;
      logic [SHIFT_WIDTH-1:0] shift_in;
      logic [EXPI_WIDTH-1:0]  exp_in;
      logic [EXPI_WIDTH-1:0]  shift_ext;

      assign sig_in    = bus.in_significand[gi*SIG_WIDTH +: SIG_WIDTH];
      assign shift_in  = bus.in_norm_shift[gi*SHIFT_WIDTH +: SHIFT_WIDTH];
      assign exp_in    = {2'b00, bus.in_exponent[gi*EXP_WIDTH +: EXP_WIDTH]};
      assign shift_ext = {{(EXPI_WIDTH-SHIFT_WIDTH){1'b0}}, shift_in};

      // Two extra exponent bits let the difference go negative without wrapping.
      assign a_sig_next[gi] = bus.in_logical_subtract[gi] ? (sig_in << shift_in) : sig_in;
      assign a_exp_next[gi] = bus.in_logical_subtract[gi] ? (exp_in - shift_ext) : exp_in;
    end
  endgenerate

  // Stage A occupancy: loads whatever is offered whenever it is allowed to move.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_reg <= 1'b0;
    end else if (a_advance) begin
      a_valid_reg <= bus.in_valid;
    end
  end

  // Stage A payload: captured on an accepted op, held while the stage is stalled.
  always_ff @(posedge clk) begin
    if (!reset && a_advance && bus.in_valid) begin
      a_sig_reg      <= a_sig_next;
      a_exp_reg      <= a_exp_next;
      a_sign_reg     <= bus.in_sign;
      a_nan_reg      <= bus.in_is_nan;
      a_inf_reg      <= bus.in_is_inf;
      a_sideband_reg <= bus.in_sideband;
    end
  end

  // Round, special-case and pack every lane; masking is left to writeback.
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      fp_round_pack_lane #(
        .EXP_WIDTH  (EXP_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
      ) u_round_pack (
        .sig    (a_sig_reg[gi]),
        .exp    (a_exp_reg[gi]),
        .sign   (a_sign_reg[gi]),
        .is_nan (a_nan_reg[gi]),
        .is_inf (a_inf_reg[gi]),
        .result (b_result_next[gi*RESULT_WIDTH +: RESULT_WIDTH])
      );
    end
  endgenerate

  // Stage B / output register: cleared on reset, refilled from A when it advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      b_valid_reg      <= 1'b0;
      out_result_reg   <= '0;
      out_sideband_reg <= '0;
    end else if (b_advance) begin
      b_valid_reg <= a_valid_reg;
      if (a_valid_reg) begin
        out_result_reg   <= b_result_next;
        out_sideband_reg <= a_sideband_reg;
      end
    end
  end

endmodule
